// File: rtl/load_store_unit_pkg.sv
// Shared types and widths for the load/store unit and its data-memory interface.
// Also holds the alignment rule so the RTL and any reference model agree on it.
package load_store_unit_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } mem_size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP,
        ST_ERR
    } lsu_state_e;

    // Size code 11 is handled as a word access.
    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLow);
        logic misaligned;
        misaligned = 1'b0;
        case (size)
            SIZE_BYTE: misaligned = 1'b0;
            SIZE_HALF: misaligned = addrLow[0];
            default:   misaligned = (addrLow != 2'b00);
        endcase
        return misaligned;
    endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Extracts the addressed byte/half/word lanes from a memory read word and
// sign- or zero-extends the result to a full data word.
module lsu_load_align
    import load_store_unit_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic [1:0]            i_addr,
    input  logic [1:0]            i_size,
    input  logic                  i_sign,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [DATA_WIDTH-1:0] w_shifted;

    assign w_shifted = i_rdata >> {i_addr, 3'b000};

    always_comb begin
        o_data = w_shifted;
        case (i_size)
            SIZE_BYTE: o_data = {{24{i_sign & w_shifted[7]}}, w_shifted[7:0]};
            SIZE_HALF: o_data = {{16{i_sign & w_shifted[15]}}, w_shifted[15:0]};
            default:   o_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Initiator side of the data-memory interface: one outstanding load/store,
// alignment check, lane steering for stores and lane extraction for loads.
module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0]            req_size,
    input  logic                  req_sign,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    lsu_state_e            r_state;
    lsu_state_e            w_nextState;
    logic                  r_we;
    logic                  r_sign;
    logic [1:0]            r_size;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [3:0]            r_be;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_loadData;
    logic                  w_accept;

    assign w_accept = (r_state == ST_IDLE) && req_valid;

    // Lane steering is computed from the live request and frozen at acceptance.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = req_wdata;
        case (req_size)
            SIZE_BYTE: begin
                w_be    = 4'b0001 << req_addr[1:0];
                w_wdata = {4{req_wdata[7:0]}};
            end
            SIZE_HALF: begin
                w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = req_wdata;
            end
        endcase
    end

    lsu_load_align u_loadAlign (
        .i_rdata (mem_rdata),
        .i_addr  (r_addr[1:0]),
        .i_size  (r_size),
        .i_sign  (r_sign),
        .o_data  (w_loadData)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState   = r_state;
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        resp_valid    = 1'b0;
        resp_err      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = ~rst;
                if (req_valid) begin
                    w_nextState = isMisaligned(req_size, req_addr[1:0]) ? ST_ERR : ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    w_nextState = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_resp_valid) begin
                    w_nextState = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid  = 1'b1;
                w_nextState = ST_IDLE;
            end
            ST_ERR: begin
                resp_valid  = 1'b1;
                resp_err    = 1'b1;
                w_nextState = ST_IDLE;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Response data is cleared at acceptance, so stores and errors complete with zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_sign  <= 1'b0;
            r_size  <= 2'b00;
            r_addr  <= '0;
            r_be    <= 4'b0000;
            r_wdata <= '0;
            r_rdata <= '0;
        end else if (w_accept) begin
            r_we    <= req_we;
            r_sign  <= req_sign;
            r_size  <= req_size;
            r_addr  <= req_addr;
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_rdata <= '0;
        end else if ((r_state == ST_WAIT) && mem_resp_valid) begin
            r_rdata <= r_we ? '0 : w_loadData;
        end
    end

    assign mem_we     = r_we;
    assign mem_addr   = {r_addr[ADDR_WIDTH-1:2], 2'b00};
    assign mem_be     = r_be;
    assign mem_wdata  = r_wdata;
    assign resp_rdata = r_rdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed transactions push expected
// responses, an independent monitor pops and compares on every resp_valid.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_sign;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    load_store_unit dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_size       (req_size),
        .req_sign       (req_sign),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_be         (mem_be),
        .mem_wdata      (mem_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every completion pulse is matched against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedResp", 32'd1, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("respErr", {31'd0, resp_err}, {31'd0, e.err});
                    checkOutput("respRdata", resp_rdata, e.rdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(
        input logic        we,
        input logic [31:0] addr,
        input logic [31:0] wdata,
        input logic [1:0]  size,
        input logic        sign,
        input logic [31:0] rdata,
        input int          readyDelay,
        input int          respDelay,
        input logic        expErr,
        input logic [31:0] expRdata,
        input logic [31:0] expAddr,
        input logic [3:0]  expBe,
        input logic [31:0] expWdata
    );
        exp_t e;
        checkOutput("reqReadyIdle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_size  = size;
        req_sign  = sign;
        e.err     = expErr;
        e.rdata   = expRdata;
        expQ.push_back(e);
        stepCycle();
        req_valid = 1'b0;
        req_wdata = 32'h0;
        req_addr  = 32'h0;
        if (expErr) begin
            checkOutput("errNoMemReq", {31'd0, mem_req_valid}, 32'd0);
            checkOutput("errRespValid", {31'd0, resp_valid}, 32'd1);
            checkOutput("errRespErr", {31'd0, resp_err}, 32'd1);
            stepCycle();
            checkOutput("errNoMemReqAfter", {31'd0, mem_req_valid}, 32'd0);
        end else begin
            for (int i = 0; i <= readyDelay; i++) begin
                checkOutput("memReqValid", {31'd0, mem_req_valid}, 32'd1);
                checkOutput("memAddr", mem_addr, expAddr);
                checkOutput("memBe", {28'd0, mem_be}, {28'd0, expBe});
                checkOutput("memWdata", mem_wdata, expWdata);
                checkOutput("memWe", {31'd0, mem_we}, {31'd0, we});
                checkOutput("reqReadyBusy", {31'd0, req_ready}, 32'd0);
                if (i == readyDelay) begin
                    mem_req_ready = 1'b1;
                end
                stepCycle();
            end
            mem_req_ready = 1'b0;
            for (int i = 0; i < respDelay; i++) begin
                checkOutput("waitNoResp", {31'd0, resp_valid}, 32'd0);
                checkOutput("waitNoMemReq", {31'd0, mem_req_valid}, 32'd0);
                stepCycle();
            end
            mem_resp_valid = 1'b1;
            mem_rdata      = rdata;
            stepCycle();
            mem_resp_valid = 1'b0;
            mem_rdata      = 32'h0;
            checkOutput("respValid", {31'd0, resp_valid}, 32'd1);
        end
        stepCycle();
        checkOutput("respPulseEnd", {31'd0, resp_valid}, 32'd0);
        checkOutput("reqReadyAfter", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        rst            = 1'b1;
        req_valid      = 1'b0;
        req_we         = 1'b0;
        req_addr       = 32'h0;
        req_wdata      = 32'h0;
        req_size       = 2'b00;
        req_sign       = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = 32'h0;
        stepCycle();
        stepCycle();
        checkOutput("rstReqReady", {31'd0, req_ready}, 32'd0);
        checkOutput("rstMemReqValid", {31'd0, mem_req_valid}, 32'd0);
        checkOutput("rstRespValid", {31'd0, resp_valid}, 32'd0);
        checkOutput("rstMemAddr", mem_addr, 32'h0);
        checkOutput("rstMemBe", {28'd0, mem_be}, 32'h0);
        checkOutput("rstMemWe", {31'd0, mem_we}, 32'd0);
        rst = 1'b0;
        stepCycle();

        // we, addr, wdata, size, sign, rdata, rdyDly, rspDly, err, expRdata, expAddr, expBe, expWdata
        applyStimulus(1'b0, 32'h103, 32'h0, 2'b00, 1'b1, 32'h8000_0000, 0, 0, 1'b0, 32'hFFFF_FF80, 32'h100, 4'b1000, 32'h0);
        applyStimulus(1'b0, 32'h103, 32'h0, 2'b00, 1'b0, 32'h8000_0000, 0, 0, 1'b0, 32'h0000_0080, 32'h100, 4'b1000, 32'h0);
        applyStimulus(1'b1, 32'h202, 32'h1234_ABCD, 2'b01, 1'b0, 32'hFFFF_FFFF, 0, 0, 1'b0, 32'h0, 32'h200, 4'b1100, 32'hABCD_ABCD);
        applyStimulus(1'b0, 32'h40, 32'h0, 2'b10, 1'b1, 32'hCAFE_F00D, 3, 2, 1'b0, 32'hCAFE_F00D, 32'h40, 4'b1111, 32'h0);
        applyStimulus(1'b0, 32'h006, 32'h0, 2'b10, 1'b0, 32'h0, 0, 0, 1'b1, 32'h0, 32'h0, 4'b0000, 32'h0);
        applyStimulus(1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 32'hDEAD_BEEF, 0, 0, 1'b0, 32'hDEAD_BEEF, 32'h10, 4'b1111, 32'h0);
        applyStimulus(1'b0, 32'h2, 32'h0, 2'b01, 1'b1, 32'h8001_0000, 1, 0, 1'b0, 32'hFFFF_8001, 32'h0, 4'b1100, 32'h0);
        applyStimulus(1'b0, 32'h0, 32'h0, 2'b01, 1'b0, 32'h1234_F00D, 0, 1, 1'b0, 32'h0000_F00D, 32'h0, 4'b0011, 32'h0);
        applyStimulus(1'b0, 32'h1, 32'h0, 2'b01, 1'b1, 32'h0, 0, 0, 1'b1, 32'h0, 32'h0, 4'b0000, 32'h0);
        applyStimulus(1'b1, 32'h301, 32'h0000_00A5, 2'b00, 1'b0, 32'h0, 0, 0, 1'b0, 32'h0, 32'h300, 4'b0010, 32'hA5A5_A5A5);

        // Reset while waiting for the memory; the late response must be dropped.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h80;
        req_size  = 2'b10;
        stepCycle();
        req_valid = 1'b0;
        checkOutput("rstSeqMemReq", {31'd0, mem_req_valid}, 32'd1);
        mem_req_ready = 1'b1;
        stepCycle();
        mem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("rstSeqReadyLow", {31'd0, req_ready}, 32'd0);
        stepCycle();
        rst = 1'b0;
        #1;
        checkOutput("rstSeqIdleNoMemReq", {31'd0, mem_req_valid}, 32'd0);
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h1357_9BDF;
        stepCycle();
        mem_resp_valid = 1'b0;
        checkOutput("rstSeqNoResp", {31'd0, resp_valid}, 32'd0);
        checkOutput("rstSeqReady", {31'd0, req_ready}, 32'd1);
        stepCycle();
        checkOutput("rstSeqStillNoResp", {31'd0, resp_valid}, 32'd0);
        checkOutput("rstSeqRdata", resp_rdata, 32'h0);

        stepCycle();
        stepCycle();
        checkOutput("pendingResp", expQ.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Initiator side of the data-memory interface. It sits between the pipeline MEM stage and a byte-addressed, word-organised data memory that may insert wait states. It accepts one load/store per transaction, checks alignment and generates word address, byte enables and lane-replicated write data. On the way back it extracts the addressed lanes from the memory response and sign- or zero-extends them.

Parameters:
ADDR_WIDTH, 32, byte address width (from the shared package)
DATA_WIDTH, 32, data width (from the shared package; fixed at 32)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  pipeline request present
req_ready  out  1  LSU accepts the request this cycle
req_we  in  1  1 = store, 0 = load
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  store data, right-aligned
req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
req_sign  in  1  1 = sign-extend load, 0 = zero-extend
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
resp_err  out  1  misaligned access, qualified by resp_valid
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts the request
mem_we  out  1  write strobe
mem_addr  out  ADDR_WIDTH  word-aligned address, bits [1:0] = 0
mem_be  out  4  byte enables
mem_wdata  out  DATA_WIDTH  lane-positioned write data
mem_resp_valid  in  1  read data or write acknowledge
mem_rdata  in  DATA_WIDTH  full word read data

Behaviour:
- One clock domain; reset is synchronous, active-high.
- Reset values: state IDLE; resp_valid, resp_err, mem_req_valid and mem_we all 0; resp_rdata, mem_addr, mem_be and mem_wdata all 0; req_ready = 0 while rst is high.
- FSM states: IDLE, REQ, WAIT, RESP, ERR. At most one transaction is outstanding.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch we, addr, wdata, size and sign.
  - If misaligned, go to ERR. Misaligned means half with addr[0]=1, or word/11 with addr[1:0]!=0.
  - Otherwise go to REQ.
- REQ:
  - mem_req_valid = 1 and the mem_* outputs are held stable until mem_req_ready.
  - On mem_req_ready, go to WAIT.
- WAIT:
  - On mem_resp_valid, capture mem_rdata and go to RESP.
  - The memory never responds in the acceptance cycle; mem_resp_valid seen in IDLE, REQ, RESP or ERR is ignored.
- RESP: resp_valid = 1, resp_err = 0, then return to IDLE.
- ERR: resp_valid = 1, resp_err = 1, resp_rdata = 0, then return to IDLE. No memory access is issued.
- Latency with a zero-wait memory: request accepted at cycle T, mem handshake at T+1, mem_resp_valid at T+2, resp_valid at T+3. A new request is accepted at T+4 at the earliest, so back-to-back throughput is one transaction per 4 cycles.
- Byte enables and write data:
  - byte: mem_be = 1 << addr[1:0]; mem_wdata = four copies of wdata[7:0].
  - half: mem_be = 0011 if addr[1]=0, else 1100; mem_wdata = two copies of wdata[15:0].
  - word: mem_be = 1111; mem_wdata = wdata.
- For loads, mem_we = 0 and mem_be carries the same pattern (informational).
- Load data: shift mem_rdata right by 8*addr[1:0], take the low 8, 16 or 32 bits, then extend per sign. Sign is ignored for word.
- Stores: resp_rdata = 0 at completion.
- Reset mid-transaction: the next cycle is IDLE with mem_req_valid = 0; a late mem_resp_valid is ignored.
- req_valid is ignored in every state except IDLE.

Decomposition:
- Shared package gets:
  - mem_size_e: SIZE_BYTE=00, SIZE_HALF=01, SIZE_WORD=10.
  - lsu_state_e.
  - ADDR_WIDTH and DATA_WIDTH, already defined there.
- Sub-module lsu_load_align: combinational, inputs rdata, addr[1:0], size, sign; output is the extended word. Reusable by the verification model.
- Byte-enable and write-data generation stays inline.

Test Plan:
- Load byte, addr 0x103, sign=1, mem_rdata 0x80_00_00_00 -> resp_rdata 0xFFFFFF80, mem_addr 0x100, mem_be 1000. With sign=0 -> 0x00000080.
- Store half, addr 0x202, wdata 0x1234ABCD -> mem_be 1100, mem_wdata 0xABCDABCD, mem_we 1, resp_valid at T+3 with rdata 0.
- Word load with mem_req_ready held low 3 cycles and mem_resp_valid delayed 2 cycles -> mem_* outputs stable throughout, single resp_valid pulse, req_ready low until completion.
- Misaligned word, addr 0x006 -> mem_req_valid never asserted, resp_valid and resp_err both 1 at T+1.
- rst asserted during WAIT, mem_resp_valid pulses one cycle after rst deasserts -> no resp_valid, state IDLE, req_ready 1.
- req_size 11, addr 0x10, mem_rdata 0xDEADBEEF -> treated as word, resp_rdata 0xDEADBEEF.
